// File: rtl/mux_32_to_1_if.sv
// Read-select bus for the 32:1 mux leaf: select and data in, combinational
// and registered selected bit out.
interface mux_32_to_1_if #(
  parameter int SEL_W = 5
);
  logic [SEL_W-1:0]      select_read;
  logic [(1<<SEL_W)-1:0] input_read;
  logic                  output_read;
  logic                  output_read_q;

  // Producer of select/data, consumer of the selected bit
  modport master (
    output select_read,
    output input_read,
    input  output_read,
    input  output_read_q
  );

  // The mux itself
  modport slave (
    input  select_read,
    input  input_read,
    output output_read,
    output output_read_q
  );
endinterface

// File: rtl/mux_32_to_1.sv
// 2**SEL_W : 1 single-bit read-select mux built as a balanced tree of 2:1
// stages, with a combinational output for tree composition and a
// registered copy for timing-closed consumers.

// One 2:1 stage: load_i[1] when sel_i is 1, else load_i[0]. A ternary keeps
// X-propagation honest: an X select yields X unless both loads agree.
module mux_32_to_1_mux2 (
  input  logic       sel_i,
  input  logic [1:0] load_i,
  output logic       out_o
);
  assign out_o = sel_i ? load_i[1] : load_i[0];
endmodule

module mux_32_to_1 #(
  parameter int SEL_W = 5
) (
  input  logic          clk,
  input  logic          reset,
  mux_32_to_1_if.slave  bus
);
  localparam int N = 1 << SEL_W;

  // All tree nodes in one flat vector, level by level. Level k occupies
  // N>>k entries starting at 2N - 2*(N>>k); level 0 is the data input and
  // the single root sits at index 2N-2. Every node is both driven and read,
  // so no level carries dead bits.
  logic [2*N-2:0] node;

  assign node[N-1:0] = bus.input_read;

  // Level k pairs adjacent nodes (2j+1, 2j) of level k-1 on select_read[k]
  for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
    localparam int IN_OFF  = 2*N - 2*(N >> k);
    localparam int OUT_OFF = 2*N - 2*(N >> (k+1));
    localparam int PAIRS   = N >> (k+1);
    for (genvar j = 0; j < PAIRS; j++) begin : g_pair
      mux_32_to_1_mux2 u_mux2 (
        .sel_i  (bus.select_read[k]),
        .load_i (node[IN_OFF+2*j+1 -: 2]),
        .out_o  (node[OUT_OFF+j])
      );
    end
  end

  assign bus.output_read = node[2*N-2];

  logic out_d;
  logic out_q;

  assign out_d = bus.output_read;

  // Registered copy of the root; synchronous active-low clear, no warm-up
  always_ff @(posedge clk) begin
    if (!reset) out_q <= 1'b0;
    else        out_q <= out_d;
  end

  assign bus.output_read_q = out_q;
endmodule

// File: tb/tb_mux_32_to_1.sv
// Directed bench for mux_32_to_1: pattern sweeps, walking one, registered
// path with reset, and 64:1 composition from two leaves.
module tb_mux_32_to_1;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mux_32_to_1_if #(.SEL_W(5)) bus ();
  mux_32_to_1 #(.SEL_W(5)) u_dut (.clk(clk), .reset(reset), .bus(bus));

  // 64:1 built from two leaves plus one 2:1 on sel[5]
  logic [63:0] data64;
  logic [5:0]  sel6;
  logic        out64;
  mux_32_to_1_if #(.SEL_W(5)) bus_lo ();
  mux_32_to_1_if #(.SEL_W(5)) bus_hi ();
  assign bus_lo.input_read  = data64[31:0];
  assign bus_hi.input_read  = data64[63:32];
  assign bus_lo.select_read = sel6[4:0];
  assign bus_hi.select_read = sel6[4:0];
  assign out64 = sel6[5] ? bus_hi.output_read : bus_lo.output_read;
  mux_32_to_1 #(.SEL_W(5)) u_lo (.clk(clk), .reset(reset), .bus(bus_lo));
  mux_32_to_1 #(.SEL_W(5)) u_hi (.clk(clk), .reset(reset), .bus(bus_hi));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sweep all selects; expected bit comes from the listed set of one-indices
  task automatic sweep(input string name, input logic [31:0] pat, input logic [31:0] ones);
    for (int i = 0; i < 32; i++) begin
      bus.input_read  = pat;
      bus.select_read = i[4:0];
      #1;
      chk($sformatf("%s_sel%0d", name, i), {63'd0, bus.output_read}, {63'd0, ones[i]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ones_a;
    logic [31:0] ones_b;
    reset           = 1'b0;
    bus.input_read  = '0;
    bus.select_read = '0;
    data64          = '0;
    sel6            = '0;

    // Reset held for two edges
    @(posedge clk); @(posedge clk); #1;
    chk("rst_q", {63'd0, bus.output_read_q}, 64'd0);

    // Combinational output ignores reset
    @(negedge clk);
    bus.input_read  = 32'hFFFF_FFFF;
    bus.select_read = 5'd7;
    #1;
    chk("rst_comb", {63'd0, bus.output_read}, 64'd1);
    chk("rst_q_hold", {63'd0, bus.output_read_q}, 64'd0);

    // Release: capture on first edge
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("rel_q", {63'd0, bus.output_read_q}, 64'd1);

    // Switch to a zero bit; q follows one edge later
    @(negedge clk);
    bus.input_read  = 32'h0001_0F2C;
    bus.select_read = 5'd0;
    #1;
    chk("sel0_comb", {63'd0, bus.output_read}, 64'd0);
    chk("sel0_q_old", {63'd0, bus.output_read_q}, 64'd1);
    @(posedge clk); #1;
    chk("sel0_q_new", {63'd0, bus.output_read_q}, 64'd0);

    // Back to a one bit
    @(negedge clk); bus.select_read = 5'd2;
    @(posedge clk); #1;
    chk("sel2_q", {63'd0, bus.output_read_q}, 64'd1);

    // Mid-stream reset clears q, comb stays 1
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_q", {63'd0, bus.output_read_q}, 64'd0);
    chk("mid_rst_comb", {63'd0, bus.output_read}, 64'd1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rel_q", {63'd0, bus.output_read_q}, 64'd1);

    // Pattern sweeps, expected one-indices listed by hand
    ones_a = '0;
    foreach (ones_a[i]) ones_a[i] = (i inside {2, 3, 5, 8, 9, 10, 11, 16});
    sweep("patA", 32'h0001_0F2C, ones_a);
    ones_b = '0;
    foreach (ones_b[i]) ones_b[i] = (i inside {0, 2, 3, 4, 5, 7, 8, 9, 11, 12, 14});
    sweep("patB", 32'h0000_5BBD, ones_b);

    // Walking one across every leaf
    for (int k = 0; k < 32; k++) begin
      bus.input_read  = 32'd1 << k;
      bus.select_read = k[4:0];
      #1;
      chk($sformatf("walk%0d_hit", k), {63'd0, bus.output_read}, 64'd1);
      if (k > 0) begin
        bus.select_read = 5'(k - 1);
        #1;
        chk($sformatf("walk%0d_lo", k), {63'd0, bus.output_read}, 64'd0);
      end
      if (k < 31) begin
        bus.select_read = 5'(k + 1);
        #1;
        chk($sformatf("walk%0d_hi", k), {63'd0, bus.output_read}, 64'd0);
      end
    end

    // 64:1 composition: 69420 = 0x10F2C, bit 16 set, bit 48 clear
    data64 = 64'd69420;
    sel6   = 6'd16; #1;
    chk("comp_sel16", {63'd0, out64}, 64'd1);
    sel6   = 6'd48; #1;
    chk("comp_sel48", {63'd0, out64}, 64'd0);
    data64 = 64'd1 << 48; #1;
    chk("comp_hi48", {63'd0, out64}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
